// File: rtl/spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_master: mode-0 SPI master, parallel word in/out, SCLK = CLK/(2*DIV)  |
// | Build option: SPI_LSB_FIRST_EN selects LSB-first shifting (default MSB). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              i_clk,
  input  logic              i_clr_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_miso,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_cs_n,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_tx, w_tx_nxt;
  logic [DATA_W-1:0] r_rx, w_rx_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_sclk, w_sclk_nxt;
  logic              r_mosi, w_mosi_nxt;
  logic              r_cs_n, w_cs_n_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic              w_tick;
  logic              w_tx_first;
  logic [DATA_W-1:0] w_tx_shift;
  logic              w_mosi_next;
  logic [DATA_W-1:0] w_rx_shift;

`ifdef SPI_LSB_FIRST_EN
  assign w_tx_first  = i_tx_data[0];
  assign w_tx_shift  = r_tx >> 1;
  assign w_mosi_next = w_tx_shift[0];
  assign w_rx_shift  = {i_miso, r_rx[DATA_W-1:1]};
`else
  assign w_tx_first  = i_tx_data[DATA_W-1];
  assign w_tx_shift  = r_tx << 1;
  assign w_mosi_next = w_tx_shift[DATA_W-1];
  assign w_rx_shift  = {r_rx[DATA_W-2:0], i_miso};
`endif

  // One tick per SCLK half-period; every active phase is a whole number of ticks.
  assign w_tick = (r_div == DIV_MAX);

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_cnt_nxt     = r_cnt;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rx_data_nxt = r_rx_data;
    w_sclk_nxt    = r_sclk;
    w_mosi_nxt    = r_mosi;
    w_cs_n_nxt    = r_cs_n;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    if (r_state != S_IDLE) begin
      w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        if (i_start) begin
          w_tx_nxt    = i_tx_data;
          w_cs_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_mosi_nxt  = w_tx_first;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_tick) begin
          w_sclk_nxt  = 1'b1;
          w_rx_nxt    = w_rx_shift;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (w_tick) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
            w_rx_nxt   = w_rx_shift;
          end else begin
            w_sclk_nxt = 1'b0;
            // r_cnt holds edges already issued, so this falling edge is the last one.
            if (r_cnt == LAST_EDGE) begin
              w_mosi_nxt  = 1'b0;
              w_state_nxt = S_HOLD;
            end else begin
              w_tx_nxt   = w_tx_shift;
              w_mosi_nxt = w_mosi_next;
            end
          end
        end
      end
      S_HOLD: begin
        if (w_tick) begin
          w_cs_n_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_rx_data_nxt = r_rx;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_cnt     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;
  assign o_cs_n    = r_cs_n;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rx_data = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_master: two spi_master instances (CLK_DIV 2 and 1) checked against |
// | a timing-formula model every cycle, plus literal latency/data checks.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_spi_master;

  localparam int W  = 8;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] tx = '0;
  logic [W-1:0] sw = '0;
  logic loopback = 1'b1;

  logic [NI-1:0] miso, sclk, mosi, cs_n, busy, done;
  logic [NI-1:0] sbit = '0;
  logic [NI-1:0][W-1:0] rx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign miso[0] = loopback ? mosi[0] : sbit[0];
  assign miso[1] = loopback ? mosi[1] : sbit[1];

  spi_master #(.DATA_W(W), .CLK_DIV(2)) u_div2 (
    .i_clk(clk), .i_clr_n(rst_n), .i_start(start), .i_tx_data(tx), .i_miso(miso[0]),
    .o_sclk(sclk[0]), .o_mosi(mosi[0]), .o_cs_n(cs_n[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_rx_data(rx[0])
  );

  spi_master #(.DATA_W(W), .CLK_DIV(1)) u_div1 (
    .i_clk(clk), .i_clr_n(rst_n), .i_start(start), .i_tx_data(tx), .i_miso(miso[1]),
    .o_sclk(sclk[1]), .o_mosi(mosi[1]), .o_cs_n(cs_n[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_rx_data(rx[1])
  );

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int total(input int i);
    return (2 * W + 1) * div_of(i);
  endfunction

  // b-th bit on the wire, in transmission order
  function automatic logic wire_bit(input logic [W-1:0] w, input int b);
`ifdef SPI_LSB_FIRST_EN
    return w[b];
`else
    return w[W-1-b];
`endif
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] at cycle %0d: got %0h, expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  // Model: t counts CLK edges since the accepting edge; DONE lands at t = total.
  logic         m_act [NI] = '{default: 1'b0};
  int           m_t   [NI] = '{default: 0};
  logic [W-1:0] m_tx  [NI] = '{default: '0};
  logic [W-1:0] m_sw  [NI] = '{default: '0};
  logic [W-1:0] m_rx  [NI] = '{default: '0};
  logic         m_lb  [NI] = '{default: 1'b0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_act[i] <= 1'b0;
        m_t[i]   <= 0;
        m_rx[i]  <= '0;
      end else if (m_act[i] && m_t[i] < total(i)) begin
        m_t[i] <= m_t[i] + 1;
        if (m_t[i] + 1 == total(i)) m_rx[i] <= m_lb[i] ? m_tx[i] : m_sw[i];
      end else if (start) begin
        m_act[i] <= 1'b1;
        m_t[i]   <= 0;
        m_tx[i]  <= tx;
        m_sw[i]  <= sw;
        m_lb[i]  <= loopback;
      end else begin
        m_act[i] <= 1'b0;
      end
    end
  end

  int   done_cnt  [NI] = '{default: 0};
  int   last_done [NI] = '{default: -1};
  int   rises     [NI] = '{default: 0};
  logic prev_sclk [NI] = '{default: 1'b0};

  always @(negedge clk) begin
    logic e_sclk, e_mosi, e_csn, e_busy, e_done;
    int p, j;
    for (int i = 0; i < NI; i++) begin
      e_sclk = 1'b0; e_mosi = 1'b0; e_csn = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      if (m_act[i]) begin
        if (m_t[i] == total(i)) begin
          e_done = 1'b1;
        end else begin
          p      = m_t[i] / div_of(i);
          e_csn  = 1'b0;
          e_busy = 1'b1;
          e_sclk = (p % 2 == 1) && (p < 2 * W);
          e_mosi = (p < 2 * W) ? wire_bit(m_tx[i], p / 2) : 1'b0;
        end
      end
      if (done[i] === 1'b1) begin
        done_cnt[i]++;
        last_done[i] = cyc;
      end
      if (sclk[i] === 1'b1 && prev_sclk[i] !== 1'b1) rises[i]++;
      prev_sclk[i] = sclk[i];

      check("sclk", i, 32'(sclk[i]), 32'(e_sclk));
      check("mosi", i, 32'(mosi[i]), 32'(e_mosi));
      check("cs_n", i, 32'(cs_n[i]), 32'(e_csn));
      check("busy", i, 32'(busy[i]), 32'(e_busy));
      check("done", i, 32'(done[i]), 32'(e_done));
      check("rx_data", i, 32'(rx[i]), 32'(m_rx[i]));

      // Slave presents bit j ahead of the rising SCLK that samples it.
      if (m_act[i] && m_t[i] < total(i)) begin
        j = m_t[i] / (2 * div_of(i));
        if (j > W - 1) j = W - 1;
        sbit[i] = wire_bit(m_sw[i], j);
      end else begin
        sbit[i] = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done0(input int target);
    int n;
    n = 0;
    while (done_cnt[0] < target && n < 300) begin
      step();
      n++;
    end
    check("wait_done_in_budget", 0, 32'(n < 300), 32'd1);
  endtask

  task automatic run_xfer(input logic [W-1:0] t, input logic lb, input logic [W-1:0] s,
                          input logic [W-1:0] exp_rx);
    int k, d0, d1, r0, r1;
    step();
    tx = t; sw = s; loopback = lb; start = 1'b1;
    d0 = done_cnt[0]; d1 = done_cnt[1]; r0 = rises[0]; r1 = rises[1];
    step();
    k = cyc;
    start = 1'b0;
    tx = ~t;
    wait_done0(d0 + 1);
    check("done_latency", 0, 32'(last_done[0] - k), 32'd34);
    check("done_latency", 1, 32'(last_done[1] - k), 32'd17);
    check("sclk_rises", 0, 32'(rises[0] - r0), 32'd8);
    check("sclk_rises", 1, 32'(rises[1] - r1), 32'd8);
    check("done_pulses", 0, 32'(done_cnt[0] - d0), 32'd1);
    check("done_pulses", 1, 32'(done_cnt[1] - d1), 32'd1);
    check("rx_literal", 0, 32'(rx[0]), 32'(exp_rx));
    check("rx_literal", 1, 32'(rx[1]), 32'(exp_rx));
    step();
  endtask

  initial begin
    int k, d0, d1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      check("reset_cs_n", i, 32'(cs_n[i]), 32'd1);
      check("reset_rx", i, 32'(rx[i]), 32'd0);
    end
    rst_n = 1'b1;
    step();

    run_xfer(8'hA5, 1'b1, 8'h00, 8'hA5);
    run_xfer(8'hFF, 1'b0, 8'h3C, 8'h3C);
    run_xfer(8'h5A, 1'b1, 8'h00, 8'h5A);
    run_xfer(8'h01, 1'b1, 8'h00, 8'h01);
    run_xfer(8'h00, 1'b0, 8'h01, 8'h01);
    run_xfer(8'h3C, 0, 8'h96, 8'h96);

    // START held high across two transfers
    step();
    tx = 8'h01; loopback = 1'b1; start = 1'b1;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    step();
    k = cyc;
    tx = 8'h80;
    wait_done0(d0 + 1);
    check("b2b_first_done", 0, 32'(last_done[0] - k), 32'd34);
    check("b2b_first_rx", 0, 32'(rx[0]), 32'h01);
    step();
    start = 1'b0;
    check("b2b_reaccept_cs_n", 0, 32'(cs_n[0]), 32'd0);
    wait_done0(d0 + 2);
    check("b2b_second_done", 0, 32'(last_done[0] - k), 32'd69);
    check("b2b_second_done", 1, 32'(last_done[1] - k), 32'd35);
    check("b2b_second_rx", 0, 32'(rx[0]), 32'h80);
    check("b2b_second_rx", 1, 32'(rx[1]), 32'h80);
    repeat (40) step();
    check("b2b_no_third", 0, 32'(done_cnt[0] - d0), 32'd2);
    check("b2b_no_third", 1, 32'(done_cnt[1] - d1), 32'd2);

    // Asynchronous reset mid-transfer
    step();
    tx = 8'hA5; loopback = 1'b1; start = 1'b1;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    step();
    k = cyc;
    start = 1'b0;
    while (cyc < k + 10) step();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("async_rst_sclk", i, 32'(sclk[i]), 32'd0);
      check("async_rst_cs_n", i, 32'(cs_n[i]), 32'd1);
      check("async_rst_busy", i, 32'(busy[i]), 32'd0);
      check("async_rst_mosi", i, 32'(mosi[i]), 32'd0);
      check("async_rst_rx", i, 32'(rx[i]), 32'd0);
    end
    step();
    step();
    rst_n = 1'b1; start = 1'b1; tx = 8'hC5; loopback = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("post_rst_accept", i, 32'(cs_n[i]), 32'd0);
      check("no_done_after_abort", i, 32'(done_cnt[i] - (i == 0 ? d0 : d1)), 32'd0);
    end
    wait_done0(d0 + 1);
    check("post_rst_rx", 0, 32'(rx[0]), 32'hC5);
    check("post_rst_rx", 1, 32'(rx[1]), 32'hC5);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
